// File: rtl/vram_arbiter_if.sv
// Request/acknowledge word bus: one instance faces the CPU, another faces the shared video RAM.
interface vram_arbiter_if;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        we;
  logic [1:0]  be;
  logic        req;
  logic        ack;

  modport master (output addr, wdata, we, be, req, input  rdata, ack);
  modport slave  (input  addr, wdata, we, be, req, output rdata, ack);
endinterface

// File: rtl/vram_arbiter.sv
// Shares one 16-bit video RAM between the scanout fetcher and the CPU, video first.
// Define VRAM_ARBITER_SNOOP_EN to merge CPU writes to the displayed word into vid_data.
module vram_arbiter (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [13:0]    vid_addr,
  output logic [15:0]    vid_data,
  vram_arbiter_if.slave  cpu,
  vram_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE, VID, CPU, HOLD} state_t;

  state_t      state, state_nxt;
  logic [13:0] last_vid_addr;
  logic        pending;
  logic        vid_change;
  logic        vid_want;
  logic [13:0] addr_q;
  logic [15:0] din_q;
  logic        we_q;
  logic [1:0]  be_q;
  logic [15:0] cpu_dout_q;

  // A change seen this cycle already counts, so a simultaneous CPU strobe cannot jump ahead of it.
  assign vid_change = (vid_addr != last_vid_addr);
  assign vid_want   = pending | vid_change;

  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default is assigned first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (vid_want)     state_nxt = VID;
        else if (cpu.req) state_nxt = CPU;
      end
      VID:     if (mem.ack)  state_nxt = IDLE;
      CPU:     if (mem.ack)  state_nxt = HOLD;
      HOLD:    if (!cpu.req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stale fetches leave pending set when the address moved on while they were in flight.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      last_vid_addr <= '0;
      pending       <= 1'b1;
    end else if (vid_change) begin
      last_vid_addr <= vid_addr;
      pending       <= 1'b1;
    end else if (state == VID && mem.ack) begin
      pending <= (addr_q != last_vid_addr);
    end
  end

  // vid_addr equals the freshest last_vid_addr value whenever a fetch is launched.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
      be_q   <= 2'b00;
    end else if (state == IDLE) begin
      if (vid_want) begin
        addr_q <= vid_addr;
        we_q   <= 1'b0;
        be_q   <= 2'b11;
      end else if (cpu.req) begin
        addr_q <= cpu.addr;
        din_q  <= cpu.wdata;
        we_q   <= cpu.we;
        be_q   <= (cpu.we && cpu.be != 2'b00) ? cpu.be : 2'b11;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vid_data   <= '0;
      cpu_dout_q <= '0;
    end else begin
      if (state == VID && mem.ack) vid_data <= mem.rdata;
`ifdef VRAM_ARBITER_SNOOP_EN
      if (state == CPU && mem.ack && we_q && addr_q == last_vid_addr) begin
        if (be_q[0]) vid_data[7:0]  <= din_q[7:0];
        if (be_q[1]) vid_data[15:8] <= din_q[15:8];
      end
`endif
      if (state == CPU && mem.ack && !we_q) cpu_dout_q <= mem.rdata;
    end
  end

  assign mem.req   = (state == VID) || (state == CPU);
  assign mem.addr  = addr_q;
  assign mem.wdata = din_q;
  assign mem.we    = we_q;
  assign mem.be    = be_q;
  assign cpu.ack   = (state == HOLD);
  assign cpu.rdata = cpu_dout_q;
endmodule
